// File: rtl/reorder_buffer_pkg.sv
// Shared types and helpers for the in-order completion buffer.
package reorder_buffer_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rob_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/reorder_buffer_ram.sv
// Payload store: one write port, one registered read port; read register holds when rd_en=0.
module reorder_buffer_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // The read register doubles as the released-data output register.
    always_ff @(posedge clk) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/reorder_buffer.sv
// Hands out sequential tags, takes completions in any order, releases in tag order (wb->out 2 cycles, stalls on out_ready).
// REORDER_BUFFER_CHECK_EN enables writeback/allocation protocol checking with a sticky err.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 64,
    parameter int TAG_WIDTH = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_en,
    output logic                 alloc_ready,
    output logic [TAG_WIDTH:0]   alloc_tag,
    input  logic                 wb_en,
    input  logic [TAG_WIDTH:0]   wb_tag,
    input  logic [WIDTH-1:0]     wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAG_WIDTH:0]   out_tag,
    output logic [TAG_WIDTH:0]   count,
    output logic                 err
);

    typedef struct packed {
        logic                 phase;
        logic [TAG_WIDTH-1:0] slot;
    } tag_t;

    localparam logic [TAG_WIDTH:0]   FULL_CNT  = (TAG_WIDTH+1)'(DEPTH);
    localparam logic [TAG_WIDTH-1:0] LAST_SLOT = TAG_WIDTH'(DEPTH - 1);

    rob_state_t           state, state_nxt;
    logic [TAG_WIDTH-1:0] sweep_idx;
    logic [TAG_WIDTH:0]   head, tail, count_q;
    logic [DEPTH-1:0]     phase_q;
    tag_t                 head_t, wb_t;
    logic                 run, alloc_fire, out_fire, head_done, load;
    logic                 wb_bad, alloc_bad, wb_ok;

    assign head_t = head;
    assign wb_t   = wb_tag;
    assign run    = (state == ST_RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (sweep_idx == LAST_SLOT) state_nxt = ST_RUN;
            default: state_nxt = state;
        endcase
    end

    assign alloc_ready = run && (count_q < FULL_CNT);
    assign alloc_fire  = alloc_en && alloc_ready;
    assign out_fire    = out_valid && out_ready;
    // A slot is complete once its stored phase matches the phase of the lap head is on.
    assign head_done   = (phase_q[head_t.slot] == head_t.phase);
    assign load        = run && head_done && (head != tail) && (!out_valid || out_ready);

    always_comb begin
        wb_bad    = 1'b0;
        alloc_bad = 1'b0;
`ifdef REORDER_BUFFER_CHECK_EN
        wb_bad    = ((wb_tag - head) >= (tail - head)) ||
                    (phase_q[wb_t.slot] == wb_t.phase);
        alloc_bad = alloc_en && !alloc_ready;
`endif
    end

    assign wb_ok = wb_en && run && !wb_bad;

    always_ff @(posedge clk) begin
        if (state == ST_INIT) phase_q[sweep_idx] <= 1'b1;
        else if (wb_ok)       phase_q[wb_t.slot] <= wb_t.phase;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) sweep_idx <= sweep_idx + 1'b1;
            if (alloc_fire)       tail      <= tail + 1'b1;
            if (load)             head      <= head + 1'b1;
            if (alloc_fire && !out_fire)      count_q <= count_q + 1'b1;
            else if (!alloc_fire && out_fire) count_q <= count_q - 1'b1;
            if (load) begin
                out_valid <= 1'b1;
                out_tag   <= head;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef REORDER_BUFFER_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                                err <= 1'b0;
        else if ((wb_en && run && wb_bad) || alloc_bad) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    assign alloc_tag = tail;
    assign count     = count_q;

    reorder_buffer_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (TAG_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wb_ok),
        .wr_addr (wb_t.slot),
        .wr_data (wb_data),
        .rd_en   (load),
        .rd_addr (head_t.slot),
        .rd_data (out_data)
    );

endmodule
